// File: rtl/sample_deserializer.sv
// Serial-to-parallel input stage: packs N_SAMPLES samples into one flattened frame for the FFT.
// Optional macro SAMPLE_DESER_OVERLAP_EN lets a new frame start in the same cycle as the frame handshake.
module sample_deserializer #(
    parameter int unsigned BIT_WIDTH = 32,
    parameter int unsigned N_SAMPLES = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [BIT_WIDTH-1:0]           recv_msg,
    input  logic                           recv_val,
    output logic                           recv_rdy,
    output logic [BIT_WIDTH*N_SAMPLES-1:0] send_msg,
    output logic                           send_val,
    input  logic                           send_rdy
);

    localparam int unsigned CNT_W = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1;
    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(N_SAMPLES - 1);

    typedef enum logic {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [BIT_WIDTH-1:0] slots [N_SAMPLES];
    logic                 accept;

    // Ready is a pure decode of state (and send_rdy in overlap mode), held low during reset.
    always_comb begin
        recv_rdy = 1'b0;
        if (!reset) begin
            if (state == COLLECT) begin
                recv_rdy = 1'b1;
            end else begin
`ifdef SAMPLE_DESER_OVERLAP_EN
                recv_rdy = send_rdy;
`else
                recv_rdy = 1'b0;
`endif
            end
        end
    end

    assign accept = recv_val && recv_rdy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= COLLECT;
            cnt      <= '0;
            send_val <= 1'b0;
            for (int i = 0; i < int'(N_SAMPLES); i++) begin
                slots[i] <= '0;
            end
        end else begin
            case (state)
                COLLECT: begin
                    if (accept) begin
                        slots[cnt] <= recv_msg;
                        if (cnt == LAST_SLOT) begin
                            cnt      <= '0;
                            state    <= FULL;
                            send_val <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                FULL: begin
                    // Slots stay frozen until the FFT takes the frame.
                    if (send_rdy) begin
                        state    <= COLLECT;
                        send_val <= 1'b0;
`ifdef SAMPLE_DESER_OVERLAP_EN
                        if (accept) begin
                            slots[0] <= recv_msg;
                            cnt      <= CNT_W'(1);
                        end
`endif
                    end
                end
                default: begin
                    state    <= COLLECT;
                    send_val <= 1'b0;
                end
            endcase
        end
    end

    for (genvar k = 0; k < int'(N_SAMPLES); k++) begin : g_pack
        assign send_msg[BIT_WIDTH*k +: BIT_WIDTH] = slots[k];
    end

endmodule

// File: tb/tb_sample_deserializer.sv
// Directed bench for sample_deserializer; overlap expectations follow SAMPLE_DESER_OVERLAP_EN.
module tb_sample_deserializer;

    localparam int unsigned BW = 32;
    localparam int unsigned NS = 8;
    localparam int unsigned FW = BW * NS;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [BW-1:0] recv_msg = '0;
    logic          recv_val = 1'b0;
    logic          recv_rdy;
    logic [FW-1:0] send_msg;
    logic          send_val;
    logic          send_rdy = 1'b0;

    int total = 0;
    int bad = 0;

    sample_deserializer #(.BIT_WIDTH(BW), .N_SAMPLES(NS)) dut (
        .clk      (clk),
        .reset    (reset),
        .recv_msg (recv_msg),
        .recv_val (recv_val),
        .recv_rdy (recv_rdy),
        .send_msg (send_msg),
        .send_val (send_val),
        .send_rdy (send_rdy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [BW-1:0] v);
        recv_val = 1'b1;
        recv_msg = v;
        cyc();
        recv_val = 1'b0;
    endtask

    // Frame whose slot k holds base+k.
    function automatic logic [FW-1:0] seq_frame(input logic [BW-1:0] base);
        logic [FW-1:0] f;
        f = '0;
        for (int k = 0; k < int'(NS); k++) begin
            f[BW*k +: BW] = base + BW'(k);
        end
        return f;
    endfunction

    task automatic test_reset();
        reset = 1'b0;
        #1 reset = 1'b1;
        #1;
        total++;
        if (send_val !== 1'b0) begin bad++; $display("FAIL reset_send_val got=%0b exp=0", send_val); end
        total++;
        if (recv_rdy !== 1'b0) begin bad++; $display("FAIL reset_recv_rdy got=%0b exp=0", recv_rdy); end
        total++;
        if (send_msg !== '0) begin bad++; $display("FAIL reset_send_msg got=%h exp=0", send_msg); end
        cyc();
        reset = 1'b0;
        #1;
        total++;
        if (recv_rdy !== 1'b1) begin bad++; $display("FAIL post_reset_recv_rdy got=%0b exp=1", recv_rdy); end
    endtask

    task automatic test_basic();
        send_rdy = 1'b1;
        for (int i = 0; i < int'(NS); i++) begin
            push(BW'(i + 1));
            if (i < int'(NS) - 1) begin
                total++;
                if (send_val !== 1'b0) begin bad++; $display("FAIL basic_early_val idx=%0d got=%0b exp=0", i, send_val); end
            end
        end
        total++;
        if (send_val !== 1'b1) begin bad++; $display("FAIL basic_val got=%0b exp=1", send_val); end
        total++;
        if (send_msg !== seq_frame(BW'(1))) begin bad++; $display("FAIL basic_msg got=%h exp=%h", send_msg, seq_frame(BW'(1))); end
        cyc();
        total++;
        if (send_val !== 1'b0) begin bad++; $display("FAIL basic_val_drop got=%0b exp=0", send_val); end
    endtask

    task automatic test_backpressure();
        logic [FW-1:0] exp;
        exp = seq_frame(BW'(32'h10));
        send_rdy = 1'b0;
        for (int i = 0; i < int'(NS); i++) push(BW'(32'h10 + i));
        total++;
        if (send_val !== 1'b1) begin bad++; $display("FAIL bp_val_rise got=%0b exp=1", send_val); end
        recv_val = 1'b1;
        recv_msg = BW'(32'hDEAD);
        for (int c = 0; c < 5; c++) begin
            cyc();
            total++;
            if (send_val !== 1'b1) begin bad++; $display("FAIL bp_val_hold cyc=%0d got=%0b exp=1", c, send_val); end
            total++;
            if (send_msg !== exp) begin bad++; $display("FAIL bp_msg_hold cyc=%0d got=%h exp=%h", c, send_msg, exp); end
            total++;
            if (recv_rdy !== 1'b0) begin bad++; $display("FAIL bp_recv_rdy cyc=%0d got=%0b exp=0", c, recv_rdy); end
        end
        recv_val = 1'b0;
        send_rdy = 1'b1;
        cyc();
        total++;
        if (send_val !== 1'b0) begin bad++; $display("FAIL bp_release got=%0b exp=0", send_val); end
        total++;
        if (send_msg[BW-1:0] !== BW'(32'h10)) begin bad++; $display("FAIL bp_slot0 got=%h exp=10", send_msg[BW-1:0]); end
    endtask

    task automatic test_reset_in_full();
        send_rdy = 1'b0;
        for (int i = 0; i < int'(NS); i++) push(BW'(32'h30 + i));
        total++;
        if (send_val !== 1'b1) begin bad++; $display("FAIL rf_val got=%0b exp=1", send_val); end
        reset = 1'b1;
        #1;
        total++;
        if (send_val !== 1'b0) begin bad++; $display("FAIL rf_val_async got=%0b exp=0", send_val); end
        total++;
        if (send_msg !== '0) begin bad++; $display("FAIL rf_msg_clear got=%h exp=0", send_msg); end
        cyc();
        reset = 1'b0;
        #1;
        total++;
        if (recv_rdy !== 1'b1) begin bad++; $display("FAIL rf_recv_rdy got=%0b exp=1", recv_rdy); end
    endtask

    task automatic test_bubbles();
        int  accepted;
        int  guard;
        logic acc;
        accepted = 0;
        guard = 0;
        send_rdy = 1'b1;
        while (accepted < int'(NS) && guard < 200) begin
            recv_val = (guard == 2) ? 1'b0 : ($urandom_range(0, 1) == 1);
            recv_msg = recv_val ? BW'(32'hA0 + accepted) : BW'(32'hBAD0 + guard);
            acc = recv_val && recv_rdy;
            cyc();
            guard++;
            if (acc) accepted++;
            if (accepted < int'(NS)) begin
                total++;
                if (send_val !== 1'b0) begin bad++; $display("FAIL bub_early_val acc=%0d got=%0b exp=0", accepted, send_val); end
            end
        end
        recv_val = 1'b0;
        total++;
        if (accepted != int'(NS)) begin bad++; $display("FAIL bub_timeout accepted=%0d exp=%0d", accepted, NS); end
        total++;
        if (send_val !== 1'b1) begin bad++; $display("FAIL bub_val got=%0b exp=1", send_val); end
        total++;
        if (send_msg !== seq_frame(BW'(32'hA0))) begin bad++; $display("FAIL bub_msg got=%h exp=%h", send_msg, seq_frame(BW'(32'hA0))); end
        cyc();
        total++;
        if (send_val !== 1'b0) begin bad++; $display("FAIL bub_drain got=%0b exp=0", send_val); end
    endtask

    task automatic test_reset_mid_frame();
        send_rdy = 1'b1;
        for (int i = 0; i < 3; i++) push(BW'(32'hC0 + i));
        reset = 1'b1;
        #1;
        total++;
        if (send_val !== 1'b0) begin bad++; $display("FAIL rm_val_in_reset got=%0b exp=0", send_val); end
        total++;
        if (recv_rdy !== 1'b0) begin bad++; $display("FAIL rm_rdy_in_reset got=%0b exp=0", recv_rdy); end
        cyc();
        total++;
        if (send_val !== 1'b0) begin bad++; $display("FAIL rm_val_reset_edge got=%0b exp=0", send_val); end
        reset = 1'b0;
        #1;
        for (int i = 0; i < int'(NS); i++) push(BW'(32'hB0 + i));
        total++;
        if (send_val !== 1'b1) begin bad++; $display("FAIL rm_val got=%0b exp=1", send_val); end
        total++;
        if (send_msg !== seq_frame(BW'(32'hB0))) begin bad++; $display("FAIL rm_msg got=%h exp=%h", send_msg, seq_frame(BW'(32'hB0))); end
        cyc();
        total++;
        if (send_val !== 1'b0) begin bad++; $display("FAIL rm_drain got=%0b exp=0", send_val); end
    endtask

    task automatic test_overlap();
        int  idx;
        int  edges;
        int  rdy_low;
        int  second_at;
        int  nframes;
        int  exp_second;
        int  exp_low;
        logic acc;
        logic [FW-1:0] f0;
        logic [FW-1:0] f1;
`ifdef SAMPLE_DESER_OVERLAP_EN
        exp_second = 16;
        exp_low = 0;
`else
        exp_second = 17;
        exp_low = 1;
`endif
        idx = 0; edges = 0; rdy_low = 0; second_at = -1; nframes = 0;
        f0 = '0; f1 = '0;
        send_rdy = 1'b1;
        while (idx < 16 && edges < 100) begin
            recv_val = 1'b1;
            recv_msg = BW'(idx);
            acc = recv_rdy;
            if (recv_rdy !== 1'b1) rdy_low++;
            cyc();
            edges++;
            if (acc) idx++;
            if (send_val === 1'b1) begin
                if (nframes == 0) f0 = send_msg;
                else if (nframes == 1) begin
                    f1 = send_msg;
                    second_at = edges;
                end
                nframes++;
            end
        end
        recv_val = 1'b0;
        total++;
        if (nframes != 2) begin bad++; $display("FAIL ov_frames got=%0d exp=2", nframes); end
        total++;
        if (f0 !== seq_frame(BW'(0))) begin bad++; $display("FAIL ov_frame0 got=%h exp=%h", f0, seq_frame(BW'(0))); end
        total++;
        if (f1 !== seq_frame(BW'(8))) begin bad++; $display("FAIL ov_frame1 got=%h exp=%h", f1, seq_frame(BW'(8))); end
        total++;
        if (rdy_low != exp_low) begin bad++; $display("FAIL ov_rdy_low got=%0d exp=%0d", rdy_low, exp_low); end
        total++;
        if (second_at != exp_second) begin bad++; $display("FAIL ov_latency got=%0d exp=%0d", second_at, exp_second); end
        cyc();
        total++;
        if (send_val !== 1'b0) begin bad++; $display("FAIL ov_drain got=%0b exp=0", send_val); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_reset_in_full();
        test_bubbles();
        test_reset_mid_frame();
        test_overlap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
